// File: rtl/sort_stream.sv
// sort_stream: accepts a burst of up to DEPTH keys, sorts them in place with
// odd-even transposition (one pass per cycle), then streams them out with the
// arrival index of each key. One job in flight at a time.
module sort_stream #(
    parameter  int DEPTH = 5,
    parameter  int KEY_W = 5,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             descend,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q;
    logic             desc_q;
    logic [CNT_W-1:0] wr_cnt, pass_cnt, rd_cnt;
    logic [KEY_W-1:0] key_q   [DEPTH];
    logic [IDX_W-1:0] tag_q   [DEPTH];
    logic [KEY_W-1:0] sort_key[DEPTH];
    logic [IDX_W-1:0] sort_tag[DEPTH];

    logic             len_ok;
    logic [CNT_W-1:0] last_cnt;

    assign len_ok   = (len != '0) && (len <= CNT_W'(DEPTH));
    assign last_cnt = len_q - CNT_W'(1);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake/status outputs, all decoded from the current state.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_key   = '0;
        out_idx   = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE:  if (start && len_ok) state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wr_cnt == last_cnt) state_d = SORT;
            end
            SORT:  if (pass_cnt == last_cnt) state_d = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                out_key   = key_q[rd_cnt[IDX_W-1:0]];
                out_idx   = tag_q[rd_cnt[IDX_W-1:0]];
                out_last  = (rd_cnt == last_cnt);
                if (out_ready && rd_cnt == last_cnt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One transposition pass: even passes pair (0,1),(2,3).., odd passes (1,2),(3,4)..;
    // pairs reaching beyond len stay untouched. Strict compare keeps ties stable.
    always_comb begin
        sort_key = key_q;
        sort_tag = tag_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if ((i % 2) == int'(pass_cnt[0]) && (i + 1) < int'(len_q)) begin
                if (desc_q ? (key_q[i] < key_q[i+1]) : (key_q[i] > key_q[i+1])) begin
                    sort_key[i]   = key_q[i+1];
                    sort_key[i+1] = key_q[i];
                    sort_tag[i]   = tag_q[i+1];
                    sort_tag[i+1] = tag_q[i];
                end
            end
        end
    end

    // Key/tag storage: written by arrivals in LOAD, rewritten by each pass in SORT.
    // NOTE: this array is small and must come up clean after reset, so it is
    // reset like ordinary flops; large RAM-style arrays would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (state_q == LOAD && in_valid) begin
            key_q[wr_cnt[IDX_W-1:0]] <= in_key;
            tag_q[wr_cnt[IDX_W-1:0]] <= wr_cnt[IDX_W-1:0];
        end else if (state_q == SORT) begin
            key_q <= sort_key;
            tag_q <= sort_tag;
        end
    end

    // Job parameters, progress counters and the bad-length error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            desc_q   <= 1'b0;
            wr_cnt   <= '0;
            pass_cnt <= '0;
            rd_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            err <= (state_q == IDLE) && start && !len_ok;
            unique case (state_q)
                IDLE: if (start && len_ok) begin
                    len_q    <= len;
                    desc_q   <= descend;
                    wr_cnt   <= '0;
                    pass_cnt <= '0;
                    rd_cnt   <= '0;
                end
                LOAD:    if (in_valid) wr_cnt <= wr_cnt + CNT_W'(1);
                SORT:    pass_cnt <= pass_cnt + CNT_W'(1);
                DRAIN:   if (out_ready) rd_cnt <= rd_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
